full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered binary full adder: adds operands a and b plus carry-in c; presents sum and carry-out one clock later.
- WIDTH=1 gives the classic 1-bit full-adder cell used in arithmetic datapaths.
- Larger WIDTH gives a ripple-carry adder built from the same cell.
- Sits in the datapath wherever a clocked add-with-carry stage is needed.

Parameters:
- WIDTH, 1, operand/sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c  input  1  carry-in.
- in_valid  input  1  qualifies a/b/c in the current cycle.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out (MSB of the full result).
- out_valid  output  1  high when sum/cout hold the result of a valid input.

Behaviour:
- Arithmetic: {cout, sum} = a + b + c, computed at WIDTH+1 bits, no truncation.
  - WIDTH=1 truth table: sum = a^b^c; cout = majority(a,b,c).
- Latency: exactly 1 cycle.
  - Inputs sampled on rising clk edge N.
  - Result visible after edge N, stable until edge N+1.
  - No combinational path from inputs to outputs.
- Valid handling:
  - in_valid=1 at edge N: sum/cout load the new result; out_valid=1 after edge N.
  - in_valid=0 at edge N: sum/cout hold their previous value; out_valid=0 after edge N.
  - Fully pipelined: a new input is accepted every cycle; no backpressure and no ready signal.
- Reset: rst_n sampled low at a rising edge forces sum=0, cout=0, out_valid=0 after that edge.
  - Reset takes priority over in_valid.
  - An input presented in the same cycle as reset is discarded.
  - First result after reset release appears one cycle after the first valid input.
- Carry chain: ripple, bit i carry-out feeds bit i+1 carry-in; bit 0 carry-in is c.
- X-safety: with in_valid=0 the a/b/c values must not affect any output.

Decomposition:
- Package full_adder_pkg:
  - constant FA_DEFAULT_WIDTH = 1;
  - constant FA_MAX_WIDTH = 64;
  - function fa_ref(a, b, c) returning the WIDTH+1-bit reference sum, shared with the bench scoreboard.
- Sub-module full_adder_bit: purely combinational 1-bit cell.
  - Inputs x, y, ci; outputs s, co.
  - Instantiated WIDTH times in a generate loop.
- Output registers and valid logic live in the top level.
- Elaboration-time assertion rejects WIDTH outside 1..64.

Test Plan:
- WIDTH=1 exhaustive: {a,b,c} = 0..7 on consecutive cycles with in_valid=1 -> {cout,sum} = 00,01,01,10,01,10,10,11, each one cycle after its input, out_valid=1.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=b=c=1 -> sum=0, cout=0, out_valid=0. Release; next valid input 1,0,0 -> sum=1, cout=0 one cycle later.
- Hold: valid input 1,1,0 then in_valid=0 with a=b=c=1 for 3 cycles -> sum=0, cout=1 held, out_valid=0 during those cycles.
- WIDTH=8 carry ripple: a=8'hFF, b=8'h00, c=1 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, c=1 -> sum=8'hFF, cout=1.
- WIDTH=8 back-to-back: 200 random valid vectors, one per cycle -> every output matches fa_ref delayed by exactly 1 cycle; no bubbles.
- Reset mid-stream: assert rst_n=0 for one cycle during a random stream -> that cycle's input discarded, outputs zero; stream resumes correctly afterwards.

Source files
------------

// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared constants and a reference add function for the registered full adder.
//   FA_DEFAULT_WIDTH : default operand width (classic 1-bit cell)
//   FA_MAX_WIDTH     : widest operand the adder is built for
//   fa_ref()         : full-precision a + b + c at FA_MAX_WIDTH+1 bits
// -----------------------------------------------------------------------------
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

  // Callers with narrower operands zero-extend them; the carry-out of a
  // WIDTH-bit add is then bit WIDTH of the result.
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    c
  );
    return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, c};
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// Purely combinational 1-bit full-adder cell.
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit      = x ^ y ^ ci
//   co   : carry out    = majority(x, y, ci)
// -----------------------------------------------------------------------------
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Registered ripple-carry adder: {cout, sum} = a + b + c, one cycle latency.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset (clears sum, cout, out_valid)
//   a, b      : WIDTH-bit unsigned operands
//   c         : carry in
//   in_valid  : qualifies a/b/c this cycle
//   sum       : registered sum bits
//   cout      : registered carry out
//   out_valid : sum/cout hold the result of the input accepted at the last edge
// -----------------------------------------------------------------------------
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
    $fatal(1, "full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             vld_q;

  // Ripple chain: carry[i] enters bit i, carry[WIDTH] is the result MSB.
  assign carry[0] = c;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    full_adder_bit u_bit (
      .x  (a[g]),
      .y  (b[g]),
      .ci (carry[g]),
      .s  (sum_d[g]),
      .co (carry[g+1])
    );
  end

  assign cout_d = carry[WIDTH];

  // Output register stage. Data only loads on a valid input, so a/b/c are
  // ignored (even if unknown) while in_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 instance signals
  logic       rst1_n, a1, b1, c1, v1;
  logic       s1, co1, ov1;
  // WIDTH=8 instance signals
  logic       rst8_n;
  logic [7:0] a8, b8;
  logic       c8, v8;
  logic [7:0] s8;
  logic       co8, ov8;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst1_n), .a(a1), .b(b1), .c(c1), .in_valid(v1),
    .sum(s1), .cout(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst8_n), .a(a8), .b(b8), .c(c8), .in_valid(v8),
    .sum(s8), .cout(co8), .out_valid(ov8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what each adder must show after an edge, from the
  // arithmetic rule a+b+c at full precision plus load/hold/reset semantics.
  logic [1:0] m1_res;
  logic       m1_vld;
  logic [8:0] m8_res;
  logic       m8_vld;

  always @(posedge clk) begin
    if (!rst1_n) begin
      m1_res <= 2'd0;
      m1_vld <= 1'b0;
    end else begin
      if (v1) m1_res <= 2'(a1) + 2'(b1) + 2'(c1);
      m1_vld <= v1;
    end
    if (!rst8_n) begin
      m8_res <= 9'd0;
      m8_vld <= 1'b0;
    end else begin
      if (v8) m8_res <= 9'(a8) + 9'(b8) + 9'(c8);
      m8_vld <= v8;
    end
  end

  // Single compare process, mid-cycle, every cycle once the model is defined.
  always @(negedge clk) begin
    if (armed) begin
      check("w1_result", {co1, s1}, m1_res);
      check("w1_valid", ov1, m1_vld);
      check("w8_result", {co8, s8}, m8_res);
      check("w8_valid", ov8, m8_vld);
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  int tab [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

  initial begin
    rst1_n = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
    rst8_n = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; v8 = 1'b0;

    // Reference function pinned to hand-computed values.
    check("fa_ref_ripple8", fa_ref(64'hFF, 64'h0, 1'b1), 65'h100);
    check("fa_ref_ff_ff_1", fa_ref(64'hFF, 64'hFF, 1'b1), 65'h1FF);
    check("fa_ref_max", fa_ref({64{1'b1}}, {64{1'b1}}, 1'b1), {1'b1, {64{1'b1}}});

    repeat (2) tick();
    armed = 1'b1;
    check("reset_w1", {ov1, co1, s1}, 3'b000);
    check("reset_w8", {ov8, co8, s8}, 10'h000);
    rst1_n = 1'b1;
    rst8_n = 1'b1;

    // WIDTH=1 exhaustive truth table, back to back.
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (i > 0) begin
        check("exh_w1", {co1, s1}, 65'(tab[i-1]));
        check("exh_w1_vld", ov1, 1'b1);
      end
      if (i < 8) begin
        {a1, b1, c1} = 3'(i);
        v1 = 1'b1;
      end else begin
        v1 = 1'b0;
      end
    end

    // Hold: valid 1+1+0, then invalid inputs must not disturb the result.
    tick();
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
    tick();
    check("hold_load", {ov1, co1, s1}, 3'b110);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_w1", {ov1, co1, s1}, 3'b010);
    end

    // Reset beats a valid input presented with it.
    rst1_n = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    tick();
    check("rst_w1_a", {ov1, co1, s1}, 3'b000);
    tick();
    check("rst_w1_b", {ov1, co1, s1}, 3'b000);
    rst1_n = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
    tick();
    check("post_rst_w1", {ov1, co1, s1}, 3'b101);
    v1 = 1'b0;

    // WIDTH=8 carry ripple across all bits.
    tick();
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
    tick();
    check("ripple_w8_a", {ov8, co8, s8}, 10'h300);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    tick();
    check("ripple_w8_b", {ov8, co8, s8}, 10'h3FF);

    // Random back-to-back stream with a one-cycle reset in the middle.
    for (int k = 0; k < 200; k++) begin
      tick();
      if (k == 101) check("midrst_w8", {ov8, co8, s8}, 10'h000);
      rst8_n = (k != 100);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      v8 = 1'b1;
    end
    tick();
    v8 = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
